// File: rtl/ftdi_fifo_bridge_if.sv
// FT245-style FTDI strobe/flag pins plus the user-side rx and tx valid/ready streams.
// master = bridge side, slave = FTDI chip + user logic side.
interface ftdi_fifo_bridge_if;
  logic       in_ftdi_rxf_n;
  logic       in_ftdi_txe_n;
  logic       out_ftdi_rd_n;
  logic       out_ftdi_wr_n;
  logic [7:0] out_rx_data;
  logic       out_rx_valid;
  logic       in_rx_ready;
  logic [7:0] in_tx_data;
  logic       in_tx_valid;
  logic       out_tx_ready;

  modport master (
    input  in_ftdi_rxf_n, in_ftdi_txe_n, in_rx_ready, in_tx_data, in_tx_valid,
    output out_ftdi_rd_n, out_ftdi_wr_n, out_rx_data, out_rx_valid, out_tx_ready
  );

  modport slave (
    output in_ftdi_rxf_n, in_ftdi_txe_n, in_rx_ready, in_tx_data, in_tx_valid,
    input  out_ftdi_rd_n, out_ftdi_wr_n, out_rx_data, out_rx_valid, out_tx_ready
  );
endinterface

// File: rtl/ftdi_fifo_bridge.sv
// FT2232H FT245 async FIFO master: moves host bytes into a 1-deep rx stream and
// drains a 1-deep tx stream to the host, owning strobe timing and the shared data bus.
module ftdi_fifo_bridge #(
  parameter int RD_LOW_CYC  = 3,
  parameter int WR_LOW_CYC  = 3,
  parameter int RECOVER_CYC = 4
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  inout  wire  [7:0]            io_ftdi_data,
  ftdi_fifo_bridge_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE, RD_LOW, WR_SETUP, WR_LOW, WR_HOLD, RECOVER
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rxfMeta_q, rxfSync_q, txeMeta_q, txeSync_q;
  logic       rdN_q, wrN_q, busOe_q;
  logic [7:0] rxData_q, rxData_d;
  logic       rxValid_q, rxValid_d;
  logic [7:0] txData_q, txData_d;
  logic       txFull_q, txFull_d;
  logic       txReady_q;
  logic       lastRead_q, lastRead_d;
  logic       rdOk, wrOk;

  assign rdOk = !rxfSync_q && !rxValid_q;
  assign wrOk = !txeSync_q && txFull_q;

  // Strobes and bus enable are registered decodes of the next state, so they never glitch.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rxfMeta_q  <= 1'b1;
      rxfSync_q  <= 1'b1;
      txeMeta_q  <= 1'b1;
      txeSync_q  <= 1'b1;
      rdN_q      <= 1'b1;
      wrN_q      <= 1'b1;
      busOe_q    <= 1'b0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      txData_q   <= '0;
      txFull_q   <= 1'b0;
      txReady_q  <= 1'b0;
      lastRead_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rxfMeta_q  <= bus.in_ftdi_rxf_n;
      rxfSync_q  <= rxfMeta_q;
      txeMeta_q  <= bus.in_ftdi_txe_n;
      txeSync_q  <= txeMeta_q;
      rdN_q      <= (state_d != RD_LOW);
      wrN_q      <= (state_d != WR_LOW);
      busOe_q    <= (state_d == WR_SETUP) || (state_d == WR_LOW) || (state_d == WR_HOLD);
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      txData_q   <= txData_d;
      txFull_q   <= txFull_d;
      txReady_q  <= !txFull_d;
      lastRead_q <= lastRead_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rxData_d   = rxData_q;
    rxValid_d  = rxValid_q;
    txData_d   = txData_q;
    txFull_d   = txFull_q;
    lastRead_d = lastRead_q;

    if (rxValid_q && bus.in_rx_ready) rxValid_d = 1'b0;
    if (bus.in_tx_valid && txReady_q) begin
      txData_d = bus.in_tx_data;
      txFull_d = 1'b1;
    end

    case (state_q)
      // lastRead_q resets to 0, so the first contended decision goes to the read side.
      IDLE: begin
        cnt_d = '0;
        if (rdOk && (!wrOk || !lastRead_q)) begin
          state_d    = RD_LOW;
          lastRead_d = 1'b1;
        end else if (wrOk) begin
          state_d    = WR_SETUP;
          lastRead_d = 1'b0;
        end
      end
      RD_LOW: begin
        if (cnt_q == 4'(RD_LOW_CYC - 1)) begin
          rxData_d  = io_ftdi_data;
          rxValid_d = 1'b1;
          state_d   = RECOVER;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_SETUP: begin
        state_d = WR_LOW;
        cnt_d   = '0;
      end
      WR_LOW: begin
        if (cnt_q == 4'(WR_LOW_CYC - 1)) begin
          state_d = WR_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_HOLD: begin
        txFull_d = 1'b0;
        state_d  = RECOVER;
        cnt_d    = '0;
      end
      // Long enough for the synchronisers to flush flag values seen during the access.
      RECOVER: begin
        if (cnt_q == 4'(RECOVER_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign io_ftdi_data      = busOe_q ? txData_q : 8'bz;
  assign bus.out_ftdi_rd_n = rdN_q;
  assign bus.out_ftdi_wr_n = wrN_q;
  assign bus.out_rx_data   = rxData_q;
  assign bus.out_rx_valid  = rxValid_q;
  assign bus.out_tx_ready  = txReady_q;

endmodule
